// File: rtl/set_pulse_injector_if.sv
// set_pulse_injector_if
//   Command handshake between the scenario sequencer and a set/pulse injector.
//   i_set_sel    : injector is the target of the current command
//   i_args_valid : i_args valid this cycle
//   i_args       : [0] "SET"/"PULSE", [1] alias, [2] value, [3] "HEX"/"DEC"/"BIN", [4] duration
//   o_ack        : one-cycle pulse, command accepted
//   o_error      : one-cycle pulse, command rejected
interface set_pulse_injector_if;
    logic  i_set_sel;
    logic  i_args_valid;
    string i_args [5];
    logic  o_ack;
    logic  o_error;

    modport master (output i_set_sel, i_args_valid, i_args, input o_ack, o_error);
    modport slave  (input i_set_sel, i_args_valid, i_args, output o_ack, o_error);
endinterface

// File: rtl/set_pulse_injector.sv
// set_pulse_injector
//   Decodes alias-addressed SET / PULSE scenario commands and drives a bank of
//   SET_SIZE channels. PULSE drives a value for D cycles, then restores the
//   value that was on the channel before the pulse started.
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   i_set_alias  : alias name per channel, latched while in reset
//   cmd          : command handshake (slave side)
//   o_set        : channel outputs
//   o_pulse_busy : channel is inside a timed pulse
module set_pulse_injector #(
    parameter int unsigned          SET_SIZE  = 5,
    parameter int unsigned          SET_WIDTH = 32,
    parameter int unsigned          CNT_WIDTH = 16,
    parameter logic [SET_WIDTH-1:0] RST_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  string                i_set_alias [SET_SIZE],
    set_pulse_injector_if.slave  cmd,
    output logic [SET_WIDTH-1:0] o_set [SET_SIZE],
    output logic [SET_SIZE-1:0]  o_pulse_busy
);
    typedef enum logic [1:0] {CMD_SET, CMD_PULSE, CMD_REJECT} cmd_kind_t;

    localparam logic [63:0] DUR_MAX = (64'd1 << CNT_WIDTH) - 64'd1;

    string                alias_q [SET_SIZE];
    logic [CNT_WIDTH-1:0] cnt_q   [SET_SIZE];
    logic [SET_WIDTH-1:0] rest_q  [SET_SIZE];

    string                a_cmd, a_alias, a_val, a_fmt, a_dur;
    cmd_kind_t            cmd_kind;
    int unsigned          cmd_ch;
    logic [SET_WIDTH-1:0] cmd_val;
    logic [CNT_WIDTH-1:0] cmd_dur;
    logic                 alias_hit;
    logic                 fmt_ok;
    logic [31:0]          raw_val;
    integer               dur_raw;
    logic                 cmd_take;

    assign cmd_take = cmd.i_set_sel && cmd.i_args_valid;

    always_comb begin
        a_cmd     = cmd.i_args[0];
        a_alias   = cmd.i_args[1];
        a_val     = cmd.i_args[2];
        a_fmt     = cmd.i_args[3];
        a_dur     = cmd.i_args[4];
        cmd_kind  = CMD_REJECT;
        cmd_ch    = 0;
        alias_hit = 1'b0;
        fmt_ok    = 1'b1;
        raw_val   = '0;
        // Ascending scan: a duplicated alias resolves to its highest index.
        for (int unsigned i = 0; i < SET_SIZE; i++) begin
            if (alias_q[i] == a_alias) begin
                alias_hit = 1'b1;
                cmd_ch    = i;
            end
        end
        if (a_fmt == "" || a_fmt == "HEX") raw_val = a_val.atohex();
        else if (a_fmt == "DEC")           raw_val = a_val.atoi();
        else if (a_fmt == "BIN")           raw_val = a_val.atobin();
        else                               fmt_ok  = 1'b0;
        cmd_val = SET_WIDTH'(raw_val);
        dur_raw = a_dur.atoi();
        cmd_dur = CNT_WIDTH'(dur_raw);
        if (alias_hit && fmt_ok) begin
            if (a_cmd == "SET")
                cmd_kind = CMD_SET;
            else if (a_cmd == "PULSE" && dur_raw > 0 && 64'(dur_raw) <= DUR_MAX)
                cmd_kind = CMD_PULSE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SET_SIZE; i++) begin
                alias_q[i] <= i_set_alias[i];
                o_set[i]   <= RST_VALUE;
                cnt_q[i]   <= '0;
                rest_q[i]  <= '0;
            end
            o_pulse_busy <= '0;
            cmd.o_ack    <= 1'b0;
            cmd.o_error  <= 1'b0;
        end else begin
            cmd.o_ack   <= cmd_take && (cmd_kind != CMD_REJECT);
            cmd.o_error <= cmd_take && (cmd_kind == CMD_REJECT);
            for (int unsigned i = 0; i < SET_SIZE; i++) begin
                // Expiry first; a command to the same channel on this edge overrides it.
                if (o_pulse_busy[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                    if (cnt_q[i] == CNT_WIDTH'(1)) begin
                        o_set[i]        <= rest_q[i];
                        o_pulse_busy[i] <= 1'b0;
                    end
                end
                if (cmd_take && i == cmd_ch) begin
                    if (cmd_kind == CMD_SET) begin
                        o_set[i]        <= cmd_val;
                        o_pulse_busy[i] <= 1'b0;
                        cnt_q[i]        <= '0;
                        rest_q[i]       <= '0;
                    end else if (cmd_kind == CMD_PULSE) begin
                        // Retrigger keeps the value saved by the first pulse.
                        if (!o_pulse_busy[i]) rest_q[i] <= o_set[i];
                        o_set[i]        <= cmd_val;
                        cnt_q[i]        <= cmd_dur;
                        o_pulse_busy[i] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/set_pulse_injector.md
# set_pulse_injector

Parametrised testbench stimulus block, successor of the single-mode set injector. It decodes scenario commands addressed by string alias and drives a bank of `SET_SIZE` output channels. Supported commands are static SET and timed PULSE, with HEX/DEC/BIN value formats, per-channel pulse counters, and acknowledge/error reporting back to the scenario sequencer. It sits between the testbench command decoder and the DUT's stimulus inputs.

## Interface
- `SET_SIZE`, 5: number of output channels.
- `SET_WIDTH`, 32: width of each channel.
- `CNT_WIDTH`, 16: pulse duration counter width.
- `RST_VALUE`, 0: value driven on every channel in reset, `SET_WIDTH` bits.
- `clk`  in  1: testbench clock, all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `i_set_alias`  in  string[SET_SIZE]: channel alias names, index = channel number.
- `i_set_sel`  in  1: block is the target of the current command.
- `i_args_valid`  in  1: `i_args` valid this cycle.
- `i_args`  in  string[5]: [0] command "SET"/"PULSE", [1] alias, [2] value, [3] format "HEX"/"DEC"/"BIN", [4] duration (decimal, PULSE only).
- `o_set`  out  [SET_WIDTH-1:0][SET_SIZE]: channel outputs.
- `o_pulse_busy`  out  [SET_SIZE]: channel currently in a timed pulse.
- `o_ack`  out  1: one-cycle pulse, command accepted.
- `o_error`  out  1: one-cycle pulse, command rejected.

## Operation
- Alias table: associative `string -> int`, built at time 0 and rebuilt on every `rst_n` falling edge from `i_set_alias`. Duplicate aliases: the last index wins.
- Command accepted only when `i_set_sel && i_args_valid` at a rising edge; otherwise inputs are ignored.
- Value conversion by `i_args[3]`: "HEX" uses atohex, "DEC" uses atoi, "BIN" uses atobin. An empty string is treated as "HEX". Result is truncated to `SET_WIDTH` LSBs, with no error.
- SET: `o_set[ch]` <= value. Any active pulse on ch is cancelled: busy cleared, counter cleared, and the restore value is discarded.
- PULSE with duration D (1..2^CNT_WIDTH-1):
  - If ch is idle, save the current `o_set[ch]` as the restore value.
  - Drive the value, load counter = D, set busy.
  - Each subsequent edge decrements the counter. When it reaches 0, `o_set[ch]` <= restore value and busy is cleared.
- PULSE on an already-busy channel (retrigger): new value driven, counter reloaded with the new D, original restore value kept.
- Channels count independently. A command to one channel never disturbs another channel's pulse.
- Rejected commands raise `o_error`, drive no `o_ack`, and change no state. Rejection causes:
  - unknown alias;
  - unknown command;
  - unknown format;
  - PULSE with D = 0;
  - PULSE with D > 2^CNT_WIDTH-1.
- Reset (async, any time, including mid-pulse): all `o_set` = `RST_VALUE`, all busy = 0, counters = 0, `o_ack` = `o_error` = 0. Commands presented while `rst_n` is low are ignored.

## Timing
- Command sampled at edge N:
  - `o_set`/busy update is visible after edge N.
  - `o_ack` or `o_error` is high for the cycle after edge N only.
- Pulse of duration D accepted at edge N:
  - new value held through edges N..N+D-1;
  - restore value visible after edge N+D;
  - busy high exactly D cycles.
- Pulse expiry and new command on the same channel at the same edge: the command wins. SET applies; PULSE retriggers.
- Back-to-back commands every cycle are supported; there is no busy back-pressure toward the sequencer.
- Reset release: the first command can be accepted at the first rising edge with `rst_n` high.

## Test plan
- Reset, then SET "CH0" "A5" "HEX" -> `o_set[0]`=0xA5 after the accepting edge; `o_ack` high 1 cycle; other channels = `RST_VALUE`.
- SET "CH1" "255" "DEC", then SET "CH2" "1010" "BIN" -> `o_set[1]`=255, `o_set[2]`=10. With `SET_WIDTH`=8, SET "CH3" "1FF" "HEX" -> `o_set[3]`=0xFF.
- `o_set[0]`=0x11, then PULSE "CH0" "FF" "HEX" "3" -> 0xFF for exactly 3 cycles with busy high, then 0x11 and busy low.
- PULSE "CH1" D=5, retrigger at cycle 2 with value 7, D=4 -> value 7 for 4 cycles, then restore to the pre-first-pulse value; a SET on CH1 mid-pulse cancels busy immediately.
- Unknown alias "XX", command "TOGGLE", format "OCT", PULSE D=0 -> each gives one `o_error` cycle, no `o_ack`, and all outputs unchanged.
- Assert `rst_n` low mid-pulse (async, between edges) -> `o_set` = `RST_VALUE` and busy = 0 immediately; no restore occurs after release.
